// File: rtl/adc_rx_pkg.sv
// rtl/adc_rx_pkg.sv - shared state encoding and defaults for the ADC SPI read master
package adc_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_QUIET
  } adc_state_e;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_DATA_BITS  = 12;
  localparam int DEF_DATA_LSB   = 0;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_QUIET_CYC  = 4;

  localparam int AVG_SAMPLES = 4;
  localparam int AVG_LOG2    = $clog2(AVG_SAMPLES);

endpackage

// File: rtl/adc_rx_sclk_gen.sv
// rtl/adc_rx_sclk_gen.sv - sclk divider for the ADC read frame; runs only while en is high
module adc_rx_sclk_gen
  import adc_rx_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic bit_done,
  output logic last_bit
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int HALF  = CLK_DIV / 2;

  logic [DIV_W-1:0] div_q, div_d, div_nxt;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             frame_end;

  // sclk_d is the level for the next cycle, so sclk leaves a flop with no decode glitches
  always_comb begin
    rise_tick = en && (div_q == DIV_W'(HALF - 1));
    bit_done  = en && (div_q == DIV_W'(CLK_DIV - 1));
    last_bit  = (bit_q == BIT_W'(FRAME_BITS - 1));
    frame_end = bit_done && last_bit;
    div_nxt   = bit_done ? '0 : div_q + 1'b1;
    div_d     = '0;
    bit_d     = '0;
    sclk_d    = 1'b1;
    if (en && !frame_end) begin
      div_d  = div_nxt;
      bit_d  = bit_done ? bit_q + 1'b1 : bit_q;
      sclk_d = (div_nxt >= DIV_W'(HALF));
    end else if (load) begin
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/adc_spi_rx.sv
// rtl/adc_spi_rx.sv - SPI read master for a 12-bit serial ADC, one sample per start.
// Optional ADC_RX_AVG_EN: 4-sample boxcar average, data_valid every 4th frame.
module adc_spi_rx
  import adc_rx_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int DATA_LSB   = DEF_DATA_LSB,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int QUIET_CYC  = DEF_QUIET_CYC
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdo,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid
);

  localparam int MAX_CYC = (SETUP_CYC > QUIET_CYC) ? SETUP_CYC : QUIET_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int SH_W    = DATA_LSB + DATA_BITS;

  adc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SH_W-1:0]      shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic                 gen_load, gen_en, rise_tick, bit_done, last_bit, frame_done;
  logic [DATA_BITS-1:0] sample;

`ifdef ADC_RX_AVG_EN
  localparam int ACC_W = DATA_BITS + AVG_LOG2;
  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;
`endif

  adc_rx_sclk_gen #(
    .FRAME_BITS(FRAME_BITS),
    .CLK_DIV   (CLK_DIV)
  ) u_sclk_gen (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (gen_load),
    .en       (gen_en),
    .sclk     (sclk),
    .rise_tick(rise_tick),
    .bit_done (bit_done),
    .last_bit (last_bit)
  );

  assign gen_en     = (state_q == ST_SHIFT);
  assign frame_done = bit_done && last_bit;
  assign sample     = shift_q[DATA_LSB +: DATA_BITS];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    gen_load = 1'b0;
`ifdef ADC_RX_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    sum       = acc_q + ACC_W'(sample);
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d  = ST_SHIFT;
          cnt_d    = '0;
          gen_load = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise_tick) shift_d = {shift_q[SH_W-2:0], sdo};
        // The last bit was sampled two cycles earlier, so shift_q is already complete here
        if (frame_done) begin
          state_d = ST_QUIET;
          cnt_d   = '0;
`ifdef ADC_RX_AVG_EN
          if (avg_cnt_q == AVG_LOG2'(AVG_SAMPLES - 1)) begin
            data_d    = DATA_BITS'(sum >> AVG_LOG2);
            dv_d      = 1'b1;
            acc_d     = '0;
            avg_cnt_d = '0;
          end else begin
            acc_d     = sum;
            avg_cnt_d = avg_cnt_q + 1'b1;
          end
`else
          data_d = sample;
          dv_d   = 1'b1;
`endif
        end
      end
      ST_QUIET: begin
        if (cnt_q == CNT_W'(QUIET_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
`ifdef ADC_RX_AVG_EN
      acc_q     <= '0;
      avg_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
`ifdef ADC_RX_AVG_EN
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
`endif
    end
  end

  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = dv_q;

endmodule
